aou_sequencer: RTL and testbench

Operand-issue and result-capture stage wrapped around the arithmetic operations unit (AOU). It accepts one arithmetic request at a time over a valid/ready handshake and latches the opcode and operands. It holds them stable on the AOU inputs for a fixed settle window, then registers the AOU result and presents it downstream over a second valid/ready handshake. It also screens illegal opcodes and divide-by-zero before the AOU result is used.

---
 rtl/aou_pkg.sv | 29 ++
 rtl/aou_sequencer.sv | 145 ++++++++++++++
 tb/tb_aou_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aou_pkg.sv
// Shared definitions for the AOU operand-issue / result-capture stage:
// opcode map, sequencer state encoding and the fixed error results.
package aou_pkg;

   localparam logic [3:0] OP_ADD = 4'b0110;
   localparam logic [3:0] OP_SUB = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b1001;

   localparam logic [7:0] DIV0_Y    = 8'hFF;
   localparam logic [7:0] ILLEGAL_Y = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // True for the four opcodes the AOU implements.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
   endfunction

   // The AOU only produces a meaningful overflow flag for add and sub.
   function automatic logic op_drives_v(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/aou_sequencer.sv
// Operand-issue and result-capture stage around the AOU.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends combinationally on valid, and a producer
// keeps valid and its payload stable until the transfer happens.
// in_ready/out_valid are pure decodes of the state register.
module aou_sequencer
   import aou_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_op,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   output logic [3:0] aou_op,
   output logic [3:0] aou_a,
   output logic [3:0] aou_b,
   input  logic [7:0] aou_y,
   input  logic       aou_v,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_y,
   output logic       out_v,
   output logic       out_err,
   output logic [7:0] done_count,
   output logic [1:0] dbg_state
);

   // Counter is loaded with SETTLE_CYCLES-1 so the result is sampled exactly
   // SETTLE_CYCLES edges after the request was accepted.
   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] r_op;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic [7:0] r_y;
   logic       r_v;
   logic       r_err;
   logic [7:0] r_done_count;

   logic       w_accept;
   logic       w_illegal;
   logic       w_div0;
   logic       w_capture;
   logic       w_handoff;

   assign w_illegal = !is_legal_op(in_op);
   assign w_div0    = (in_op == OP_DIV) && (in_b == 4'd0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode and the per-cycle datapath strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_handoff   = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = (w_illegal || w_div0) ? DONE : SETTLE;
            end
         end
         SETTLE: begin
            if (r_cnt == 4'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_handoff   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand latch, settle counter, result capture and completion counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= 4'd0;
         r_op         <= 4'd0;
         r_a          <= 4'd0;
         r_b          <= 4'd0;
         r_y          <= 8'h00;
         r_v          <= 1'b0;
         r_err        <= 1'b0;
         r_done_count <= 8'h00;
      end else begin
         if (w_accept) begin
            r_op  <= in_op;
            r_a   <= in_a;
            r_b   <= in_b;
            r_cnt <= CNT_INIT;
            // Error results are decided here; the AOU output is never used.
            if (w_illegal) begin
               r_y   <= ILLEGAL_Y;
               r_v   <= 1'b0;
               r_err <= 1'b1;
            end else if (w_div0) begin
               r_y   <= DIV0_Y;
               r_v   <= 1'b0;
               r_err <= 1'b1;
            end
         end
         if ((r_state == SETTLE) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_y   <= aou_y;
            // aou_v is undriven for mult/div, so mask it.
            r_v   <= op_drives_v(r_op) ? aou_v : 1'b0;
            r_err <= 1'b0;
         end
         if (w_handoff) begin
            r_done_count <= r_done_count + 8'd1;
         end
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = (r_state == DONE);
   assign aou_op     = r_op;
   assign aou_a      = r_a;
   assign aou_b      = r_b;
   assign out_y      = r_y;
   assign out_v      = r_v;
   assign out_err    = r_err;
   assign done_count = r_done_count;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_aou_sequencer.sv
// Bench for aou_sequencer: a behavioural AOU beside the DUT, a
// transaction-level reference model with an expected-result queue,
// directed cases from the test plan, then randomized traffic.
module tb_aou_sequencer;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_op = 4'd0;
   logic [3:0] in_a = 4'd0;
   logic [3:0] in_b = 4'd0;
   logic [3:0] aou_op;
   logic [3:0] aou_a;
   logic [3:0] aou_b;
   logic [7:0] aou_y;
   logic       aou_v;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_y;
   logic       out_v;
   logic       out_err;
   logic [7:0] done_count;
   logic [1:0] dbg_state;
   logic       junk_v = 1'b0;

   int         n_total = 0;
   int         n_bad   = 0;
   int         exp_count = 0;
   logic [9:0] exp_q[$];   // {y[7:0], v, err}

   aou_sequencer #(.SETTLE_CYCLES(SETTLE)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .aou_op(aou_op), .aou_a(aou_a), .aou_b(aou_b),
      .aou_y(aou_y), .aou_v(aou_v),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_v(out_v), .out_err(out_err),
      .done_count(done_count), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Behavioural AOU: 8-bit results, signed 4-bit overflow for add/sub,
   // and a junk overflow flag for mult/div that the stage must mask.
   always_comb begin
      aou_y = 8'h00;
      aou_v = junk_v;
      case (aou_op)
         4'b0110: begin
            aou_y = {4'b0, aou_a} + {4'b0, aou_b};
            aou_v = (aou_a[3] == aou_b[3]) && (aou_y[3] != aou_a[3]);
         end
         4'b0111: begin
            aou_y = {4'b0, aou_a} - {4'b0, aou_b};
            aou_v = (aou_a[3] != aou_b[3]) && (aou_y[3] != aou_a[3]);
         end
         4'b1000: aou_y = {4'b0, aou_a} * {4'b0, aou_b};
         4'b1001: aou_y = (aou_b == 4'd0) ? 8'hFF : ({4'b0, aou_a} / {4'b0, aou_b});
         default: aou_y = 8'h5A;
      endcase
   end

   always @(negedge clk) junk_v <= 1'($urandom);

   // ---------------- reference model ----------------
   function automatic bit ref_is_err(input logic [3:0] op, input logic [3:0] b);
      if (!(op inside {4'd6, 4'd7, 4'd8, 4'd9})) return 1'b1;
      return (op == 4'd9) && (b == 4'd0);
   endfunction

   function automatic logic [9:0] ref_result(input logic [3:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
      int sa, sb, r;
      sa = (a >= 8) ? int'(a) - 16 : int'(a);
      sb = (b >= 8) ? int'(b) - 16 : int'(b);
      case (op)
         4'd6: begin r = sa + sb; return {8'(int'(a) + int'(b)), (r > 7 || r < -8), 1'b0}; end
         4'd7: begin r = sa - sb; return {8'(int'(a) - int'(b)), (r > 7 || r < -8), 1'b0}; end
         4'd8: return {8'(int'(a) * int'(b)), 1'b0, 1'b0};
         4'd9: begin
            if (b == 0) return {8'hFF, 1'b0, 1'b1};
            return {8'(int'(a) / int'(b)), 1'b0, 1'b0};
         end
         default: return {8'h00, 1'b0, 1'b1};
      endcase
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_values();
      check("rst_in_ready",  {31'd0, in_ready},  1);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_y",     {24'd0, out_y},     0);
      check("rst_out_v",     {31'd0, out_v},     0);
      check("rst_out_err",   {31'd0, out_err},   0);
      check("rst_aou_op",    {28'd0, aou_op},    0);
      check("rst_aou_a",     {28'd0, aou_a},     0);
      check("rst_aou_b",     {28'd0, aou_b},     0);
      check("rst_done_cnt",  {24'd0, done_count}, 0);
      check("rst_state",     {30'd0, dbg_state}, 0);
   endtask

   // ---------------- driver ----------------
   // One full transaction: offer, accept, wait for result, optional
   // backpressure (with an optional ignored second request), handoff.
   task automatic do_req(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input int bp, input bit poke);
      logic [9:0] exp;
      int         n;
      int         lat;
      int         exp_lat;
      logic [7:0] held_y;
      @(negedge clk);
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(ref_result(op, a, b));
      exp_lat = ref_is_err(op, b) ? 0 : SETTLE;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op = 4'($urandom); in_a = 4'($urandom); in_b = 4'($urandom);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 50) begin
         check("busy_in_ready", {31'd0, in_ready}, 0);
         check("settle_hold_a", {28'd0, aou_a}, {28'd0, a});
         @(negedge clk);
         lat++;
      end
      check("latency", lat, exp_lat);
      if (!out_valid) return;
      if (exp_q.size() == 0) begin
         check("queue_empty", 0, 1);
         return;
      end
      exp = exp_q.pop_front();
      check("out_y",   {24'd0, out_y},   {24'd0, exp[9:2]});
      check("out_v",   {31'd0, out_v},   {31'd0, exp[1]});
      check("out_err", {31'd0, out_err}, {31'd0, exp[0]});
      check("aou_op",  {28'd0, aou_op},  {28'd0, op});
      check("aou_b",   {28'd0, aou_b},   {28'd0, b});
      held_y = out_y;
      for (int i = 0; i < bp; i++) begin
         if (poke) begin
            in_valid = 1'b1; in_op = 4'd6; in_a = 4'd1; in_b = 4'd1;
         end
         @(negedge clk);
         check("bp_out_valid", {31'd0, out_valid}, 1);
         check("bp_in_ready",  {31'd0, in_ready},  0);
         check("bp_out_y",     {24'd0, out_y},     {24'd0, held_y});
         check("bp_aou_a",     {28'd0, aou_a},     {28'd0, a});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      exp_count = (exp_count + 1) % 256;
      @(negedge clk);
      check("post_out_valid", {31'd0, out_valid}, 0);
      check("post_in_ready",  {31'd0, in_ready},  1);
      check("done_count",     {24'd0, done_count}, exp_count);
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] op;
      logic [3:0] b;
      int         pick;

      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b0;
      @(negedge clk);
      check_reset_values();

      // Directed cases.
      do_req(4'b0110, 4'd3, 4'd4, 0, 1'b0);   // add, y=07
      do_req(4'b0110, 4'd5, 4'd4, 0, 1'b0);   // add overflow
      do_req(4'b1000, 4'd3, 4'd5, 0, 1'b0);   // mult, y=0F, v masked
      do_req(4'b1001, 4'd9, 4'd0, 0, 1'b0);   // divide by zero
      do_req(4'b0000, 4'd2, 4'd2, 0, 1'b0);   // illegal opcode
      do_req(4'b0111, 4'd2, 4'd7, 5, 1'b1);   // sub with backpressure and ignored poke
      do_req(4'b1001, 4'd14, 4'd3, 2, 1'b0);  // ordinary divide

      // Reset in the middle of the settle window: request is dropped.
      @(negedge clk);
      in_op = 4'b0110; in_a = 4'd1; in_b = 4'd2; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_settle", {31'd0, in_ready}, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      check_reset_values();
      for (int i = 0; i < SETTLE + 3; i++) begin
         @(negedge clk);
         check("dropped_no_valid", {31'd0, out_valid}, 0);
      end

      // Counter wrap: 256 adds bring done_count back to 00.
      apply_reset(2);
      for (int i = 0; i < 256; i++) begin
         do_req(4'b0110, 4'($urandom), 4'($urandom), 0, 1'b0);
      end
      check("wrap_done_count", {24'd0, done_count}, 0);

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            0, 1: op = 4'b0110;
            2, 3: op = 4'b0111;
            4, 5: op = 4'b1000;
            6, 7: op = 4'b1001;
            default: op = 4'($urandom);
         endcase
         b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
         do_req(op, 4'($urandom), b, $urandom_range(0, 3), 1'($urandom));
      end

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      n_bad++;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
